// File: rtl/pin_sync_pcint.sv
// Port input block: two-flop pad synchronizer, PINx read path, pin-change mask
// register and the pin-change flag / interrupt request with post-reset warm-up.
module pin_sync_pcint #(
  parameter int                 p_width     = 8,
  parameter logic [p_width-1:0] p_impl_mask = 8'hFF
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [p_width-1:0] pin_in,
  output logic [p_width-1:0] pin_rdata,
  input  logic [p_width-1:0] pcmsk_wdata,
  input  logic               pcmsk_wbe,
  output logic [p_width-1:0] pcmsk_rdata,
  input  logic               pcif_clr,
  input  logic               pcie,
  input  logic               irq_ack,
  output logic               pcif,
  output logic               irq
);

  logic [p_width-1:0] s1;
  logic [p_width-1:0] s2;
  logic [p_width-1:0] prev;
  logic [p_width-1:0] pcmsk;
  logic [p_width-1:0] chg;
  logic [1:0]         warm_cnt;
  logic               warm_done;
  logic               chg_any;
  logic               pcif_d;

  // Synchronizer chain plus the one-cycle-delayed copy used for edge detection;
  // prev follows s2 unconditionally so warm-up ends with prev already aligned.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= pin_in;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pcmsk <= '0;
    end else if (pcmsk_wbe) begin
      pcmsk <= pcmsk_wdata & p_impl_mask;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      warm_cnt <= 2'd0;
    end else if (!warm_done) begin
      warm_cnt <= warm_cnt + 2'd1;
    end
  end

  assign warm_done = (warm_cnt == 2'd3);
  assign chg       = (s2 ^ prev) & pcmsk & p_impl_mask;
  assign chg_any   = warm_done & (|chg);

  // Set takes priority over clear so an edge arriving with the clear is kept.
  always_comb begin
    pcif_d = pcif;
    if (pcif_clr || irq_ack) begin
      pcif_d = 1'b0;
    end
    if (chg_any) begin
      pcif_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pcif <= 1'b0;
    end else begin
      pcif <= pcif_d;
    end
  end

  assign pin_rdata   = s2 & p_impl_mask;
  assign pcmsk_rdata = pcmsk;
  assign irq         = pcif & pcie;

endmodule

// File: tb/tb_pin_sync_pcint.sv
// Bench for pin_sync_pcint: a full-width instance and one with only the low
// nibble implemented, driven from shared inputs.
module tb_pin_sync_pcint;

  logic       clk;
  logic       nrst;
  logic [7:0] pin_in;
  logic [7:0] pcmsk_wdata;
  logic       pcmsk_wbe;
  logic       pcif_clr;
  logic       pcie;
  logic       irq_ack;

  logic [7:0] pin_rdata;
  logic [7:0] pcmsk_rdata;
  logic       pcif;
  logic       irq;
  logic [7:0] pin_rdata_b;
  logic [7:0] pcmsk_rdata_b;
  logic       pcif_b;
  logic       irq_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  pin_sync_pcint #(.p_width(8), .p_impl_mask(8'hFF)) dut_a (
    .clk(clk), .nrst(nrst), .pin_in(pin_in), .pin_rdata(pin_rdata),
    .pcmsk_wdata(pcmsk_wdata), .pcmsk_wbe(pcmsk_wbe), .pcmsk_rdata(pcmsk_rdata),
    .pcif_clr(pcif_clr), .pcie(pcie), .irq_ack(irq_ack), .pcif(pcif), .irq(irq)
  );

  pin_sync_pcint #(.p_width(8), .p_impl_mask(8'h0F)) dut_b (
    .clk(clk), .nrst(nrst), .pin_in(pin_in), .pin_rdata(pin_rdata_b),
    .pcmsk_wdata(pcmsk_wdata), .pcmsk_wbe(pcmsk_wbe), .pcmsk_rdata(pcmsk_rdata_b),
    .pcif_clr(pcif_clr), .pcie(pcie), .irq_ack(irq_ack), .pcif(pcif_b), .irq(irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the pads and record what each instance must show on pin_rdata two edges later.
  task automatic drive_pins(input logic [7:0] v);
    exp_t x;
    pin_in = v;
    x.a = v;
    x.b = v & 8'h0F;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    nrst = 1'b0; pin_in = 8'hFF; pcmsk_wdata = 8'h00; pcmsk_wbe = 1'b0;
    pcif_clr = 1'b0; pcie = 1'b1; irq_ack = 1'b0;
    repeat (3) tick();
    checks++; if (pin_rdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_pin_rdata: got %h expected 00", pin_rdata); end
    checks++; if (pcmsk_rdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_pcmsk: got %h expected 00", pcmsk_rdata); end
    checks++; if (pcif !== 1'b0 || irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_flag: got pcif=%b irq=%b expected 0 0", pcif, irq); end
    checks++; if (pin_rdata_b !== 8'h00 || pcif_b !== 1'b0 || irq_b !== 1'b0) begin failures++; $display("[TB] FAIL reset_b: got %h %b %b expected 00 0 0", pin_rdata_b, pcif_b, irq_b); end
    nrst = 1'b1;
    drive_pins(8'hFF);
    pcmsk_wdata = 8'hFF; pcmsk_wbe = 1'b1;
    tick();
    pcmsk_wbe = 1'b0;
    checks++; if (pcmsk_rdata !== 8'hFF) begin failures++; $display("[TB] FAIL warm_pcmsk: got %h expected FF", pcmsk_rdata); end
    checks++; if (pcmsk_rdata_b !== 8'h0F) begin failures++; $display("[TB] FAIL warm_pcmsk_b: got %h expected 0F", pcmsk_rdata_b); end
    tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a) begin failures++; $display("[TB] FAIL warm_pin_rdata: got %h expected %h", pin_rdata, e.a); end
    checks++; if (pin_rdata_b !== e.b) begin failures++; $display("[TB] FAIL warm_pin_rdata_b: got %h expected %h", pin_rdata_b, e.b); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pcif !== 1'b0 || pcif_b !== 1'b0 || irq !== 1'b0) begin failures++; $display("[TB] FAIL warm_no_flag[%0d]: got pcif=%b pcif_b=%b irq=%b expected 0 0 0", i, pcif, pcif_b, irq); end
    end
  endtask

  task automatic test_masked_change();
    pcmsk_wdata = 8'h00; pcmsk_wbe = 1'b1;
    tick();
    pcmsk_wbe = 1'b0;
    checks++; if (pcmsk_rdata !== 8'h00) begin failures++; $display("[TB] FAIL mask_clear: got %h expected 00", pcmsk_rdata); end
    drive_pins(8'h00);
    tick(); tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a) begin failures++; $display("[TB] FAIL fall_pin_rdata: got %h expected %h", pin_rdata, e.a); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pcif !== 1'b0) begin failures++; $display("[TB] FAIL masked_off_no_flag[%0d]: got %b expected 0", i, pcif); end
    end
    pcmsk_wdata = 8'h04; pcmsk_wbe = 1'b1;
    tick();
    pcmsk_wbe = 1'b0;
    drive_pins(8'h04);
    tick();
    tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a) begin failures++; $display("[TB] FAIL pin2_rdata: got %h expected %h", pin_rdata, e.a); end
    checks++; if (pcif !== 1'b0) begin failures++; $display("[TB] FAIL pin2_flag_early: got %b expected 0", pcif); end
    tick();
    checks++; if (pcif !== 1'b1 || irq !== 1'b1) begin failures++; $display("[TB] FAIL pin2_flag: got pcif=%b irq=%b expected 1 1", pcif, irq); end
    checks++; if (pcif_b !== 1'b1) begin failures++; $display("[TB] FAIL pin2_flag_b: got %b expected 1", pcif_b); end
    pcie = 1'b0;
    #1;
    checks++; if (irq !== 1'b0 || pcif !== 1'b1) begin failures++; $display("[TB] FAIL pcie_gate: got irq=%b pcif=%b expected 0 1", irq, pcif); end
    pcie = 1'b1;
    pcif_clr = 1'b1;
    tick();
    pcif_clr = 1'b0;
    checks++; if (pcif !== 1'b0 || pcif_b !== 1'b0) begin failures++; $display("[TB] FAIL sw_clear: got pcif=%b pcif_b=%b expected 0 0", pcif, pcif_b); end
  endtask

  task automatic test_old_mask();
    drive_pins(8'h00);
    tick();
    tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a) begin failures++; $display("[TB] FAIL oldmask_pin_rdata: got %h expected %h", pin_rdata, e.a); end
    pcmsk_wdata = 8'h00; pcmsk_wbe = 1'b1;
    tick();
    pcmsk_wbe = 1'b0;
    checks++; if (pcif !== 1'b1) begin failures++; $display("[TB] FAIL oldmask_flag: got %b expected 1", pcif); end
    checks++; if (pcmsk_rdata !== 8'h00) begin failures++; $display("[TB] FAIL oldmask_newmask: got %h expected 00", pcmsk_rdata); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++; if (pcif !== 1'b0 || pcif_b !== 1'b0) begin failures++; $display("[TB] FAIL ack_clear: got pcif=%b pcif_b=%b expected 0 0", pcif, pcif_b); end
  endtask

  task automatic test_unmasked_pin();
    pcmsk_wdata = 8'h04; pcmsk_wbe = 1'b1;
    tick();
    pcmsk_wbe = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_pins((k == 0) ? 8'h20 : 8'h00);
      tick();
      tick();
      e = sb.pop_front();
      checks++; if (pin_rdata !== e.a || pin_rdata_b !== e.b) begin failures++; $display("[TB] FAIL pin5_rdata[%0d]: got %h/%h expected %h/%h", k, pin_rdata, pin_rdata_b, e.a, e.b); end
      tick();
      checks++; if (pcif !== 1'b0) begin failures++; $display("[TB] FAIL pin5_no_flag[%0d]: got %b expected 0", k, pcif); end
    end
  endtask

  task automatic test_back_to_back();
    drive_pins(8'h04);
    tick(); tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a) begin failures++; $display("[TB] FAIL b2b_rise_rdata: got %h expected %h", pin_rdata, e.a); end
    tick();
    checks++; if (pcif !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_flag: got %b expected 1", pcif); end
    drive_pins(8'h00);
    tick();
    tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a) begin failures++; $display("[TB] FAIL b2b_fall_rdata: got %h expected %h", pin_rdata, e.a); end
    pcif_clr = 1'b1;
    tick();
    pcif_clr = 1'b0;
    checks++; if (pcif !== 1'b1) begin failures++; $display("[TB] FAIL set_wins: got %b expected 1", pcif); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checks++; if (pcif !== 1'b0 || irq !== 1'b0) begin failures++; $display("[TB] FAIL lone_ack: got pcif=%b irq=%b expected 0 0", pcif, irq); end
    pcif_clr = 1'b1; irq_ack = 1'b1;
    tick();
    pcif_clr = 1'b0; irq_ack = 1'b0;
    tick();
    checks++; if (pcif !== 1'b0) begin failures++; $display("[TB] FAIL idle_clear: got %b expected 0", pcif); end
  endtask

  task automatic test_impl_mask();
    pcmsk_wdata = 8'hFF; pcmsk_wbe = 1'b1;
    tick();
    pcmsk_wbe = 1'b0;
    checks++; if (pcmsk_rdata_b !== 8'h0F) begin failures++; $display("[TB] FAIL impl_pcmsk_b: got %h expected 0F", pcmsk_rdata_b); end
    checks++; if (pcmsk_rdata !== 8'hFF) begin failures++; $display("[TB] FAIL impl_pcmsk_a: got %h expected FF", pcmsk_rdata); end
    drive_pins(8'hF0);
    tick();
    tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a || pin_rdata_b !== e.b) begin failures++; $display("[TB] FAIL impl_pin_rdata: got %h/%h expected %h/%h", pin_rdata, pin_rdata_b, e.a, e.b); end
    tick();
    checks++; if (pcif !== 1'b1) begin failures++; $display("[TB] FAIL impl_flag_a: got %b expected 1", pcif); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (pcif_b !== 1'b0 || irq_b !== 1'b0) begin failures++; $display("[TB] FAIL impl_no_flag_b[%0d]: got pcif=%b irq=%b expected 0 0", i, pcif_b, irq_b); end
      tick();
    end
  endtask

  task automatic test_reset_midop();
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (pcif !== 1'b0 || irq !== 1'b0) begin failures++; $display("[TB] FAIL midreset_flag: got pcif=%b irq=%b expected 0 0", pcif, irq); end
    checks++; if (pcmsk_rdata !== 8'h00 || pin_rdata !== 8'h00) begin failures++; $display("[TB] FAIL midreset_regs: got pcmsk=%h pin=%h expected 00 00", pcmsk_rdata, pin_rdata); end
    sb.delete();
    tick();
    tick();
    nrst = 1'b1;
    drive_pins(8'hF0);
    pcmsk_wdata = 8'hFF; pcmsk_wbe = 1'b1;
    tick();
    pcmsk_wbe = 1'b0;
    tick();
    e = sb.pop_front();
    checks++; if (pin_rdata !== e.a || pin_rdata_b !== e.b) begin failures++; $display("[TB] FAIL rewarm_pin_rdata: got %h/%h expected %h/%h", pin_rdata, pin_rdata_b, e.a, e.b); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pcif !== 1'b0 || irq !== 1'b0) begin failures++; $display("[TB] FAIL rewarm_no_flag[%0d]: got pcif=%b irq=%b expected 0 0", i, pcif, irq); end
    end
  endtask

  initial begin
    test_reset();
    test_masked_change();
    test_old_mask();
    test_unmasked_pin();
    test_back_to_back();
    test_impl_mask();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
